// File: rtl/conv3d_cfg_pkg.sv
// conv3d_cfg_pkg: register address map, descriptor field widths, CTRL bit
// indices and FSM state encoding shared by the conv3d config front-end.
package conv3d_cfg_pkg;

    localparam logic [5:0] ADDR_WADDR      = 6'd0;
    localparam logic [5:0] ADDR_WLENGTH    = 6'd1;
    localparam logic [5:0] ADDR_WPREFETCH  = 6'd2;
    localparam logic [5:0] ADDR_XBASE      = 6'd10;
    localparam logic [5:0] ADDR_YBASE      = 6'd11;
    localparam logic [5:0] ADDR_ZBASE      = 6'd12;
    localparam logic [5:0] ADDR_XOFFSET    = 6'd13;
    localparam logic [5:0] ADDR_YOFFSET    = 6'd14;
    localparam logic [5:0] ADDR_WIDTH_IN   = 6'd15;
    localparam logic [5:0] ADDR_HEIGHT_OUT = 6'd16;
    localparam logic [5:0] ADDR_LENGTH_IN  = 6'd17;
    localparam logic [5:0] ADDR_LENGTH_OUT = 6'd18;
    localparam logic [5:0] ADDR_COMMIT     = 6'd19;
    localparam logic [5:0] ADDR_CTRL       = 6'd20;
    localparam logic [5:0] ADDR_STATUS     = 6'd21;

    localparam int GEOM_W = 9;
    localparam int LEN_W  = 18;
    localparam int WLEN_W = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_ERR_CLR = 1;
    localparam int CTRL_IRQ_ACK = 2;
    localparam int CTRL_IRQ_EN  = 3;

    // Address-independent part of a layer descriptor; the AW-wide address
    // fields are prepended by the top, which owns the AW parameter.
    typedef struct packed {
        logic [GEOM_W-1:0] width_in;
        logic [GEOM_W-1:0] height_out;
        logic [LEN_W-1:0]  length_in;
        logic [LEN_W-1:0]  length_out;
    } desc_geom_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/conv3d_cfg_queue_if.sv
// conv3d_cfg_queue_if: config bus plus engine-side descriptor handshake.
// Optional macro CONV3D_CFG_READBACK_EN adds the config_rdata signal.
interface conv3d_cfg_queue_if #(
    parameter int AW = 30
);
    logic          config_ena;
    logic [5:0]    config_addr;
    logic [31:0]   config_data;
`ifdef CONV3D_CFG_READBACK_EN
    logic [31:0]   config_rdata;
`endif
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_xbase;
    logic [AW-1:0] cfg_ybase;
    logic [AW-1:0] cfg_zbase;
    logic [AW-1:0] cfg_xoffset;
    logic [AW-1:0] cfg_yoffset;
    logic [8:0]    cfg_width_in;
    logic [8:0]    cfg_height_out;
    logic [17:0]   cfg_length_in;
    logic [17:0]   cfg_length_out;
    logic          conv_done;
    logic          cfg_prefetch;
    logic [AW-1:0] cfg_waddr;
    logic [7:0]    cfg_length_w;

    modport slave (
        input  config_ena, config_addr, config_data, cfg_ready, conv_done,
`ifdef CONV3D_CFG_READBACK_EN
        output config_rdata,
`endif
        output cfg_valid, cfg_xbase, cfg_ybase, cfg_zbase, cfg_xoffset,
               cfg_yoffset, cfg_width_in, cfg_height_out, cfg_length_in,
               cfg_length_out, cfg_prefetch, cfg_waddr, cfg_length_w
    );

    modport master (
        output config_ena, config_addr, config_data, cfg_ready, conv_done,
`ifdef CONV3D_CFG_READBACK_EN
        input  config_rdata,
`endif
        input  cfg_valid, cfg_xbase, cfg_ybase, cfg_zbase, cfg_xoffset,
               cfg_yoffset, cfg_width_in, cfg_height_out, cfg_length_in,
               cfg_length_out, cfg_prefetch, cfg_waddr, cfg_length_w
    );

endinterface

// File: rtl/conv3d_cfg_fifo.sv
// conv3d_cfg_fifo: synchronous DEPTH-entry descriptor FIFO with wrapping
// pointers and an occupancy count. Flush has priority over push/pop; the
// caller guarantees push only when not full (or popping) and pop only when
// non-empty. Storage is not reset, only the pointers and count are.
module conv3d_cfg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Descriptor storage write
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNTW'(DEPTH));

endmodule

// File: rtl/conv3d_cfg_queue.sv
// conv3d_cfg_queue: stages per-layer register writes, queues committed
// descriptors, issues them one at a time to the conv3d engine and tracks
// completion with a done counter and interrupt.
// Optional macro CONV3D_CFG_READBACK_EN enables the config_rdata readback mux.
module conv3d_cfg_queue
    import conv3d_cfg_pkg::*;
#(
    parameter int AW    = 30,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    conv3d_cfg_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    busy,
    output logic                    err_overflow,
    output logic                    irq
);
    localparam int QW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] xbase;
        logic [AW-1:0] ybase;
        logic [AW-1:0] zbase;
        logic [AW-1:0] xoffset;
        logic [AW-1:0] yoffset;
        desc_geom_t    geom;
    } desc_t;
    localparam int DW = $bits(desc_t);

    state_e              state, state_nxt;
    desc_t               stage;
    desc_t               head;
    logic [DW-1:0]       head_bits;
    logic [AW-1:0]       waddr;
    logic [WLEN_W-1:0]   wlength;
    logic [CW-1:0]       done_cnt;
    logic                irq_en, irq_pend, prefetch;
    logic                fifo_full, valid;
    logic                wr_ctrl, commit, flush, pop, push, done_evt, nonempty_nxt;
    logic                unused_data;

    assign wr_ctrl  = bus.config_ena && (bus.config_addr == ADDR_CTRL);
    assign commit   = bus.config_ena && (bus.config_addr == ADDR_COMMIT) && bus.config_data[0];
    assign flush    = wr_ctrl && bus.config_data[CTRL_FLUSH];
    assign pop      = (state == ST_ISSUE) && bus.cfg_ready;
    // A full queue still accepts a commit when the head leaves on the same edge.
    assign push     = commit && !flush && (!fifo_full || pop);
    assign done_evt = (state == ST_BUSY) && bus.conv_done;
    // Look-ahead occupancy lets a commit into an empty queue be offered next cycle.
    assign nonempty_nxt = !flush && (push || (q_count > QW'(pop)));
    assign unused_data  = ^bus.config_data;

    // Staging descriptor and weight registers, low bits of the write data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage   <= '0;
            waddr   <= '0;
            wlength <= '0;
        end else if (bus.config_ena) begin
            case (bus.config_addr)
                ADDR_WADDR:      waddr                 <= bus.config_data[AW-1:0];
                ADDR_WLENGTH:    wlength               <= bus.config_data[WLEN_W-1:0];
                ADDR_XBASE:      stage.xbase           <= bus.config_data[AW-1:0];
                ADDR_YBASE:      stage.ybase           <= bus.config_data[AW-1:0];
                ADDR_ZBASE:      stage.zbase           <= bus.config_data[AW-1:0];
                ADDR_XOFFSET:    stage.xoffset         <= bus.config_data[AW-1:0];
                ADDR_YOFFSET:    stage.yoffset         <= bus.config_data[AW-1:0];
                ADDR_WIDTH_IN:   stage.geom.width_in   <= bus.config_data[GEOM_W-1:0];
                ADDR_HEIGHT_OUT: stage.geom.height_out <= bus.config_data[GEOM_W-1:0];
                ADDR_LENGTH_IN:  stage.geom.length_in  <= bus.config_data[LEN_W-1:0];
                ADDR_LENGTH_OUT: stage.geom.length_out <= bus.config_data[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Prefetch pulse, irq bookkeeping, done counter and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prefetch     <= 1'b0;
            irq_en       <= 1'b0;
            irq_pend     <= 1'b0;
            done_cnt     <= '0;
            err_overflow <= 1'b0;
        end else begin
            prefetch <= bus.config_ena && (bus.config_addr == ADDR_WPREFETCH) && bus.config_data[0];
            if (wr_ctrl) irq_en <= bus.config_data[CTRL_IRQ_EN];
            // A completion in the same cycle as an ack keeps the interrupt pending.
            if (done_evt) begin
                done_cnt <= done_cnt + CW'(1);
                irq_pend <= 1'b1;
            end else if (wr_ctrl && bus.config_data[CTRL_IRQ_ACK]) begin
                irq_pend <= 1'b0;
            end
            if (commit && !flush && fifo_full && !pop) begin
                err_overflow <= 1'b1;
            end else if (wr_ctrl && bus.config_data[CTRL_ERR_CLR]) begin
                err_overflow <= 1'b0;
            end
        end
    end

    conv3d_cfg_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (stage),
        .rdata (head_bits),
        .count (q_count),
        .full  (fifo_full)
    );

    // Issue FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Issue FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (nonempty_nxt) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (pop)               state_nxt = ST_BUSY;
                else if (!nonempty_nxt) state_nxt = ST_IDLE;
            end
            ST_BUSY:  if (done_evt) state_nxt = nonempty_nxt ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign head  = head_bits;
    assign valid = (state == ST_ISSUE);
    assign busy  = (state == ST_BUSY);
    assign irq   = irq_pend & irq_en;

    assign bus.cfg_valid      = valid;
    assign bus.cfg_xbase      = valid ? head.xbase           : '0;
    assign bus.cfg_ybase      = valid ? head.ybase           : '0;
    assign bus.cfg_zbase      = valid ? head.zbase           : '0;
    assign bus.cfg_xoffset    = valid ? head.xoffset         : '0;
    assign bus.cfg_yoffset    = valid ? head.yoffset         : '0;
    assign bus.cfg_width_in   = valid ? head.geom.width_in   : '0;
    assign bus.cfg_height_out = valid ? head.geom.height_out : '0;
    assign bus.cfg_length_in  = valid ? head.geom.length_in  : '0;
    assign bus.cfg_length_out = valid ? head.geom.length_out : '0;
    assign bus.cfg_prefetch   = prefetch;
    assign bus.cfg_waddr      = waddr;
    assign bus.cfg_length_w   = wlength;

`ifdef CONV3D_CFG_READBACK_EN
    // Combinational register readback
    always_comb begin
        bus.config_rdata = '0;
        case (bus.config_addr)
            ADDR_WADDR:      bus.config_rdata = 32'(waddr);
            ADDR_WLENGTH:    bus.config_rdata = 32'(wlength);
            ADDR_XBASE:      bus.config_rdata = 32'(stage.xbase);
            ADDR_YBASE:      bus.config_rdata = 32'(stage.ybase);
            ADDR_ZBASE:      bus.config_rdata = 32'(stage.zbase);
            ADDR_XOFFSET:    bus.config_rdata = 32'(stage.xoffset);
            ADDR_YOFFSET:    bus.config_rdata = 32'(stage.yoffset);
            ADDR_WIDTH_IN:   bus.config_rdata = 32'(stage.geom.width_in);
            ADDR_HEIGHT_OUT: bus.config_rdata = 32'(stage.geom.height_out);
            ADDR_LENGTH_IN:  bus.config_rdata = 32'(stage.geom.length_in);
            ADDR_LENGTH_OUT: bus.config_rdata = 32'(stage.geom.length_out);
            ADDR_CTRL:       bus.config_rdata = 32'({irq_en, 3'b000});
            ADDR_STATUS:     bus.config_rdata = 32'({done_cnt, busy, err_overflow, irq, q_count});
            default: ;
        endcase
    end
`endif

endmodule

// File: tb/tb_conv3d_cfg_queue.sv
// tb_conv3d_cfg_queue: directed stimulus with a descriptor scoreboard; a
// monitor pops the expected descriptor on every cfg_valid/cfg_ready handshake.
module tb_conv3d_cfg_queue;

    typedef struct packed {
        logic [29:0] xbase;
        logic [29:0] ybase;
        logic [29:0] zbase;
        logic [29:0] xoffset;
        logic [29:0] yoffset;
        logic [8:0]  width_in;
        logic [8:0]  height_out;
        logic [17:0] length_in;
        logic [17:0] length_out;
    } exp_desc_t;

    logic        clk;
    logic        rst;
    logic [2:0]  q_count;
    logic        busy;
    logic        err_overflow;
    logic        irq;

    exp_desc_t   model;
    exp_desc_t   sb[$];
    int          passed;
    int          total;
    int          pf_cnt;
    int          exp_done;

    conv3d_cfg_queue_if #(.AW(30)) bus ();

    conv3d_cfg_queue #(
        .AW    (30),
        .DEPTH (4),
        .CW    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .q_count      (q_count),
        .busy         (busy),
        .err_overflow (err_overflow),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Descriptor monitor: compares the offered head on each accepted handshake
    always @(negedge clk) begin
        exp_desc_t got;
        exp_desc_t want;
        if (rst && bus.cfg_valid && bus.cfg_ready) begin
            got = {bus.cfg_xbase, bus.cfg_ybase, bus.cfg_zbase, bus.cfg_xoffset,
                   bus.cfg_yoffset, bus.cfg_width_in, bus.cfg_height_out,
                   bus.cfg_length_in, bus.cfg_length_out};
            total++;
            if (sb.size() == 0) begin
                $display("FAIL issue_unexpected: got xbase 0x%0h required no issue", got.xbase);
            end else begin
                want = sb.pop_front();
                if (got === want) passed++;
                else $display("FAIL issue_desc: got 0x%0h required 0x%0h", got, want);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.cfg_prefetch === 1'b1) pf_cnt++;
    end

    task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        bus.config_ena  = 1'b1;
        bus.config_addr = a;
        bus.config_data = d;
        @(posedge clk); #2;
        bus.config_ena  = 1'b0;
        case (a)
            6'd10: model.xbase      = d[29:0];
            6'd11: model.ybase      = d[29:0];
            6'd12: model.zbase      = d[29:0];
            6'd13: model.xoffset    = d[29:0];
            6'd14: model.yoffset    = d[29:0];
            6'd15: model.width_in   = d[8:0];
            6'd16: model.height_out = d[8:0];
            6'd17: model.length_in  = d[17:0];
            6'd18: model.length_out = d[17:0];
            default: ;
        endcase
    endtask

    task automatic commit(input bit accepted);
        if (accepted) sb.push_back(model);
        cfg_write(6'd19, 32'h1);
    endtask

    task automatic accept_one();
        bus.cfg_ready = 1'b1;
        @(posedge clk); #2;
        bus.cfg_ready = 1'b0;
    endtask

    task automatic pulse_done(input bit with_ack, input logic [31:0] ctrl);
        @(posedge clk); #2;
        bus.conv_done = 1'b1;
        if (with_ack) begin
            bus.config_ena  = 1'b1;
            bus.config_addr = 6'd20;
            bus.config_data = ctrl;
        end
        @(posedge clk); #2;
        bus.conv_done  = 1'b0;
        bus.config_ena = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, busy, 1);
    endtask

    initial begin
        passed = 0; total = 0; pf_cnt = 0; exp_done = 0;
        model = '0;
        rst = 1'b0;
        bus.config_ena = 1'b0; bus.config_addr = '0; bus.config_data = '0;
        bus.cfg_ready = 1'b0; bus.conv_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", bus.cfg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_qcount", q_count, 0);
        check("rst_err", err_overflow, 0);
        check("rst_irq", irq, 0);
        check("rst_prefetch", bus.cfg_prefetch, 0);
        check("rst_waddr", bus.cfg_waddr, 0);
        rst = 1'b1;

        // Single descriptor: one-cycle offer latency, then accept and complete
        cfg_write(6'd10, 32'h100);
        cfg_write(6'd17, 32'h3FFFF);
        cfg_write(6'd15, 32'h3FF);
        commit(1);
        check("t1_valid", bus.cfg_valid, 1);
        check("t1_xbase", bus.cfg_xbase, 64'h100);
        check("t1_len_in", bus.cfg_length_in, 64'h3FFFF);
        check("t1_width_trunc", bus.cfg_width_in, 64'h1FF);
        check("t1_qcount", q_count, 1);
        accept_one();
        check("t1_busy", busy, 1);
        check("t1_qcount_pop", q_count, 0);
        check("t1_valid_low", bus.cfg_valid, 0);
        pulse_done(0, 32'h0);
        exp_done++;
        check("t1_idle", busy, 0);
        check("t1_done_cnt", dut.done_cnt, exp_done);

        // Overflow with no ready, then push+pop on a full queue
        for (int i = 1; i <= 5; i++) begin
            cfg_write(6'd10, 32'(i));
            commit(i <= 4);
            if (i == 4) begin
                check("t2_q4", q_count, 4);
                check("t2_no_err", err_overflow, 0);
            end
        end
        check("t2_q_full", q_count, 4);
        check("t2_err", err_overflow, 1);
        check("t2_head", bus.cfg_xbase, 1);
        cfg_write(6'd20, 32'h2);
        check("t2_err_clr", err_overflow, 0);
        cfg_write(6'd10, 32'h6);
        @(posedge clk); #2;
        sb.push_back(model);
        bus.cfg_ready = 1'b1;
        bus.config_ena = 1'b1; bus.config_addr = 6'd19; bus.config_data = 32'h1;
        @(posedge clk); #2;
        bus.cfg_ready = 1'b0; bus.config_ena = 1'b0;
        check("t2_pushpop_q", q_count, 4);
        check("t2_pushpop_err", err_overflow, 0);
        check("t2_pushpop_busy", busy, 1);
        pulse_done(0, 32'h0);
        exp_done++;
        check("t2_reissue", bus.cfg_valid, 1);
        check("t2_next_head", bus.cfg_xbase, 2);
        cfg_write(6'd20, 32'h1);
        sb.delete();
        check("t2_flush_q", q_count, 0);
        check("t2_flush_valid", bus.cfg_valid, 0);
        check("t2_flush_busy", busy, 0);

        // Back-to-back jobs with ready held high
        bus.cfg_ready = 1'b1;
        cfg_write(6'd10, 32'hA);
        commit(1);
        cfg_write(6'd10, 32'hB);
        commit(1);
        check("t3_busy1", busy, 1);
        check("t3_q1", q_count, 1);
        repeat (2) @(posedge clk);
        pulse_done(0, 32'h0);
        exp_done++;
        wait_busy("t3_busy2");
        repeat (2) @(posedge clk);
        pulse_done(0, 32'h0);
        exp_done++;
        bus.cfg_ready = 1'b0;
        check("t3_done_cnt", dut.done_cnt, exp_done);
        check("t3_idle_busy", busy, 0);
        check("t3_idle_valid", bus.cfg_valid, 0);
        check("t3_idle_q", q_count, 0);

        // Interrupt enable, ack, idle completion ignored, done+ack collision
        cfg_write(6'd20, 32'h4);
        check("t4_irq_acked", irq, 0);
        cfg_write(6'd20, 32'h8);
        check("t4_irq_en_only", irq, 0);
        commit(1);
        accept_one();
        pulse_done(0, 32'h0);
        exp_done++;
        check("t4_irq_set", irq, 1);
        cfg_write(6'd20, 32'h4);
        check("t4_irq_ack", irq, 0);
        cfg_write(6'd20, 32'h8);
        pulse_done(0, 32'h0);
        check("t4_idle_done_cnt", dut.done_cnt, exp_done);
        check("t4_idle_done_irq", irq, 0);
        commit(1);
        accept_one();
        pulse_done(1, 32'hC);
        exp_done++;
        check("t4_done_ack_same", irq, 1);
        cfg_write(6'd20, 32'h4);
        check("t4_final_ack", irq, 0);

        // Weight registers and prefetch pulses
        cfg_write(6'd0, 32'hC000_1234);
        check("t5_waddr_trunc", bus.cfg_waddr, 64'h1234);
        cfg_write(6'd1, 32'h1AB);
        check("t5_wlen_trunc", bus.cfg_length_w, 64'hAB);
        cfg_write(6'd2, 32'h1);
        check("t5_pf1_high", bus.cfg_prefetch, 1);
        @(posedge clk); #2;
        check("t5_pf1_low", bus.cfg_prefetch, 0);
        cfg_write(6'd2, 32'h1);
        check("t5_pf2_high", bus.cfg_prefetch, 1);
        @(posedge clk); #2;
        check("t5_pf2_low", bus.cfg_prefetch, 0);
        cfg_write(6'd2, 32'h0);
        check("t5_pf_zero", bus.cfg_prefetch, 0);
        commit(1);
        check("t5_q1", q_count, 1);
        cfg_write(6'd20, 32'h1);
        sb.delete();
        check("t5_flush_q", q_count, 0);
        check("t5_flush_err", err_overflow, 0);
        check("t5_flush_valid", bus.cfg_valid, 0);

        // Reset while busy with two queued
        commit(1);
        accept_one();
        commit(0);
        commit(0);
        check("t6_busy", busy, 1);
        check("t6_q2", q_count, 2);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", bus.cfg_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_q", q_count, 0);
        check("t6_rst_waddr", bus.cfg_waddr, 0);
        sb.delete();
        model = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check("t6_after_valid", bus.cfg_valid, 0);

        check("sb_drained", sb.size(), 0);
        check("pf_pulses", pf_cnt, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
